alu_srcb_stage: RTL

//  Registered, parametrised ALU operand-B source stage for the multi-cycle MIPS datapath.

---
 rtl/alu_srcb_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_srcb_stage.sv
// ALU operand-B source stage: selects and registers operand B behind a valid/ready
// handshake, with a one-entry skid so in_ready never depends combinationally on out_ready.
module alu_srcb_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int SHAMT     = 2,
  parameter int CONST_INC = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           sel,
  input  logic                 imm_signed,
  input  logic [WIDTH-1:0]     b_reg,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_operand,
  input  logic                 err_clear,
  output logic                 err_sticky
);

  typedef enum logic [2:0] {
    SelReg    = 3'b000,
    SelInc    = 3'b001,
    SelExt    = 3'b010,
    SelBranch = 3'b011,
    SelUpper  = 3'b100,
    SelZero   = 3'b101,
    SelRsvd0  = 3'b110,
    SelRsvd1  = 3'b111
  } srcSel_e;

  srcSel_e          selCode;
  logic [WIDTH-1:0] extFill;
  logic [WIDTH-1:0] extImm;
  logic [WIDTH-1:0] newOperand;
  logic             reservedSel;

  logic             outValid;
  logic [WIDTH-1:0] outOperand;
  logic             skidFull;
  logic [WIDTH-1:0] skidOperand;
  logic             inReadyReg;
  logic             errReg;

  logic             accept;
  logic             consume;

  assign selCode = srcSel_e'(sel);
  assign extFill = {WIDTH{imm_signed & imm[IMM_WIDTH-1]}};
  assign extImm  = (extFill << IMM_WIDTH) | WIDTH'(imm);

  always_comb begin
    newOperand  = '0;
    reservedSel = 1'b0;
    case (selCode)
      SelReg:    newOperand = b_reg;
      SelInc:    newOperand = WIDTH'(CONST_INC);
      SelExt:    newOperand = extImm;
      SelBranch: newOperand = extImm << SHAMT;
      SelUpper:  newOperand = WIDTH'(imm) << (WIDTH - IMM_WIDTH);
      SelZero:   newOperand = '0;
      default:   reservedSel = 1'b1;
    endcase
  end

  assign accept  = in_valid & inReadyReg;
  assign consume = outValid & out_ready;

  // The skid entry only drains into the output entry, so FIFO order is preserved;
  // in_ready is re-registered from the skid occupancy that results from this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid    <= 1'b0;
      outOperand  <= '0;
      skidFull    <= 1'b0;
      skidOperand <= '0;
      inReadyReg  <= 1'b0;
    end else if (skidFull && consume) begin
      outOperand <= skidOperand;
      skidFull   <= 1'b0;
      inReadyReg <= 1'b1;
    end else if (accept && (!outValid || consume)) begin
      outValid   <= 1'b1;
      outOperand <= newOperand;
      inReadyReg <= 1'b1;
    end else if (accept) begin
      skidFull    <= 1'b1;
      skidOperand <= newOperand;
      inReadyReg  <= 1'b0;
    end else begin
      if (consume) outValid <= 1'b0;
      inReadyReg <= !skidFull;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   errReg <= 1'b0;
    else if (accept && reservedSel) errReg <= 1'b1;
    else if (err_clear)             errReg <= 1'b0;
  end

  assign in_ready    = inReadyReg;
  assign out_valid   = outValid;
  assign out_operand = outOperand;
  assign err_sticky  = errReg;

endmodule
